// File: rtl/clint_axi_timer.sv
// RISC-V CLINT on an AXI4 slave port: prescaled 64-bit mtime, per-hart mtimecmp/msip,
// registered timer interrupts. Read and write channels run as independent FSMs.
module clint_axi_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          NUM_HARTS = 1,
  parameter int          TICK_DIV  = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          araddr,
  input  logic                 arvalid,
  input  logic [3:0]           arid,
  input  logic [7:0]           arlen,
  input  logic [2:0]           arsize,
  input  logic [1:0]           arburst,
  output logic                 arready,
  output logic [31:0]          rdata,
  output logic [1:0]           rresp,
  output logic                 rvalid,
  output logic                 rlast,
  output logic [3:0]           rid,
  input  logic                 rready,
  input  logic [31:0]          awaddr,
  input  logic                 awvalid,
  input  logic [3:0]           awid,
  input  logic [7:0]           awlen,
  input  logic [2:0]           awsize,
  input  logic [1:0]           awburst,
  output logic                 awready,
  input  logic [31:0]          wdata,
  input  logic [3:0]           wstrb,
  input  logic                 wvalid,
  input  logic                 wlast,
  output logic                 wready,
  output logic [1:0]           bresp,
  output logic                 bvalid,
  output logic [3:0]           bid,
  input  logic                 bready,
  output logic [NUM_HARTS-1:0] mtip,
  output logic [NUM_HARTS-1:0] msip,
  output logic [2:0]           dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and the slave holds payload stable while valid is high.

  localparam int             PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic       {R_IDLE, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  r_state_t             r_state, r_next;
  w_state_t             w_state, w_next;
  logic [63:0]          mtime;
  logic [PW-1:0]        presc;
  logic                 tick;
  logic [63:0]          mtimecmp [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip_q, mtip_q;
  logic [7:0]           r_len, r_beat, w_len, w_beat;
  logic [15:0]          w_off;
  logic                 w_ok, wr_fire, w_end;
  logic                 rd_hit;
  logic [31:0]          rd_val;
  logic                 unused_ok;

  assign unused_ok = ^{arsize, arburst, awsize, awburst};

  function automatic logic is_mapped(input logic [31:0] a);
    logic hit;
    hit = (a[15:0] == 16'hBFF8) || (a[15:0] == 16'hBFFC);
    for (int h = 0; h < NUM_HARTS; h++) begin
      hit = hit || (a[15:0] == 16'(4 * h)) || (a[15:0] == 16'(16'h4000 + 8 * h)) ||
            (a[15:0] == 16'(16'h4004 + 8 * h));
    end
    return hit && (a[31:16] == BASE_ADDR[31:16]);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = s[b] ? d[8*b +: 8] : old[8*b +: 8];
    return res;
  endfunction

  always_comb begin
    rd_hit = is_mapped(araddr);
    rd_val = '0;
    if (araddr[15:0] == 16'hBFF8) rd_val = mtime[31:0];
    if (araddr[15:0] == 16'hBFFC) rd_val = mtime[63:32];
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (araddr[15:0] == 16'(4 * h))           rd_val = {31'b0, msip_q[h]};
      if (araddr[15:0] == 16'(16'h4000 + 8 * h)) rd_val = mtimecmp[h][31:0];
      if (araddr[15:0] == 16'(16'h4004 + 8 * h)) rd_val = mtimecmp[h][63:32];
    end
  end

  // Read FSM
  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) r_next = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        rlast  = (r_beat == r_len);
        if (rready && rlast) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= R_IDLE;
      r_len   <= '0;
      r_beat  <= '0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= '0;
    end else begin
      r_state <= r_next;
      if (r_state == R_IDLE && arvalid) begin
        rid    <= arid;
        r_len  <= arlen;
        r_beat <= '0;
        rdata  <= rd_hit ? rd_val : 32'h0;
        rresp  <= (rd_hit && arlen == 8'd0) ? 2'b00 : 2'b10;
      end else if (r_state == R_DATA && rready) begin
        r_beat <= r_beat + 8'd1;
      end
    end
  end

  // Write FSM; every W beat is accepted, but only a mapped single-beat write commits.
  assign w_end   = wlast || (w_beat == w_len);
  assign wr_fire = (w_state == W_DATA) && wvalid && w_ok;

  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && w_end) w_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state <= W_IDLE;
      w_off   <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_ok    <= 1'b0;
      bid     <= '0;
      bresp   <= '0;
    end else begin
      w_state <= w_next;
      if (w_state == W_IDLE && awvalid) begin
        bid    <= awid;
        w_off  <= awaddr[15:0];
        w_len  <= awlen;
        w_beat <= '0;
        w_ok   <= is_mapped(awaddr) && (awlen == 8'd0);
      end else if (w_state == W_DATA && wvalid) begin
        w_beat <= w_beat + 8'd1;
        if (w_end) bresp <= (w_ok && wlast && w_beat == w_len) ? 2'b00 : 2'b10;
      end
    end
  end

  // Timer state; a write to either mtime half wins over that cycle's increment.
  assign tick = (presc == PRE_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      presc  <= '0;
      mtime  <= '0;
      msip_q <= '0;
      mtip_q <= '0;
      for (int h = 0; h < NUM_HARTS; h++) mtimecmp[h] <= '1;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (wr_fire && w_off == 16'hBFF8)
        mtime <= {mtime[63:32], merge(mtime[31:0], wdata, wstrb)};
      else if (wr_fire && w_off == 16'hBFFC)
        mtime <= {merge(mtime[63:32], wdata, wstrb), mtime[31:0]};
      else if (tick)
        mtime <= mtime + 64'd1;
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (wr_fire && w_off == 16'(4 * h) && wstrb[0]) msip_q[h] <= wdata[0];
        if (wr_fire && w_off == 16'(16'h4000 + 8 * h))
          mtimecmp[h][31:0] <= merge(mtimecmp[h][31:0], wdata, wstrb);
        if (wr_fire && w_off == 16'(16'h4004 + 8 * h))
          mtimecmp[h][63:32] <= merge(mtimecmp[h][63:32], wdata, wstrb);
        mtip_q[h] <= (mtime >= mtimecmp[h]);
      end
    end
  end

  assign mtip      = mtip_q;
  assign msip      = msip_q;
  assign dbg_state = {r_state, w_state};

endmodule

// File: tb/tb_clint_axi_timer.sv
// Directed bench for clint_axi_timer: a TICK_DIV=1 two-hart instance and a TICK_DIV=4
// instance share all inputs; expected values are hand-derived from the cycle count.
module tb_clint_axi_timer;

  logic        clock, reset;
  logic [31:0] araddr, awaddr, wdata;
  logic        arvalid, rready, awvalid, wvalid, wlast, bready;
  logic [3:0]  arid, awid, wstrb;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;

  logic        arready, rvalid, rlast, awready, wready, bvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;
  logic [3:0]  rid, bid;
  logic [1:0]  mtip, msip;
  logic [2:0]  dbg_state;

  logic        arready_d4, rvalid_d4, rlast_d4, awready_d4, wready_d4, bvalid_d4;
  logic [31:0] rdata_d4;
  logic [1:0]  rresp_d4, bresp_d4;
  logic [3:0]  rid_d4, bid_d4;
  logic [0:0]  mtip_d4, msip_d4;
  logic [2:0]  dbg_state_d4;

  int          n_cmp, n_err, cycle;
  logic [31:0] exp_q[$];

  clint_axi_timer #(.NUM_HARTS(2), .TICK_DIV(1)) u_dut (
    .clock(clock), .reset(reset),
    .araddr(araddr), .arvalid(arvalid), .arid(arid), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast), .rid(rid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awid(awid), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wlast(wlast), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bid(bid), .bready(bready),
    .mtip(mtip), .msip(msip), .dbg_state(dbg_state)
  );

  clint_axi_timer #(.NUM_HARTS(1), .TICK_DIV(4)) u_div4 (
    .clock(clock), .reset(reset),
    .araddr(araddr), .arvalid(arvalid), .arid(arid), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arready(arready_d4),
    .rdata(rdata_d4), .rresp(rresp_d4), .rvalid(rvalid_d4), .rlast(rlast_d4), .rid(rid_d4),
    .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awid(awid), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awready(awready_d4),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wlast(wlast), .wready(wready_d4),
    .bresp(bresp_d4), .bvalid(bvalid_d4), .bid(bid_d4), .bready(bready),
    .mtip(mtip_d4), .msip(msip_d4), .dbg_state(dbg_state_d4)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // cycle equals mtime of the TICK_DIV=1 instance until mtime is written
  always @(posedge clock) begin
    if (reset) cycle <= 0;
    else       cycle <= cycle + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cycle < target) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                          input int stall, input logic [1:0] eresp, output int hs_c);
    logic [31:0] e;
    e = exp_q.pop_front();
    araddr = addr; arlen = len; arid = id; arvalid = 1'b1;
    hs_c = cycle;
    chk("arready", arready, 1'b1);
    @(posedge clock); #1;
    arvalid = 1'b0;
    for (int i = 0; i < stall; i++) begin
      chk("stall_rvalid", rvalid, 1'b1);
      chk("stall_rdata", rdata, e);
      @(posedge clock); #1;
    end
    rready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      chk("rvalid", rvalid, 1'b1);
      chk("rdata", rdata, e);
      chk("rresp", rresp, eresp);
      chk("rlast", rlast, i == int'(len));
      chk("rid", rid, id);
      @(posedge clock); #1;
    end
    rready = 1'b0;
    chk("r_done", rvalid, 1'b0);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] data,
                           input logic [3:0] strb, input logic [3:0] id, input logic [1:0] eresp,
                           output int commit_c);
    awaddr = addr; awlen = len; awid = id; awvalid = 1'b1;
    chk("awready", awready, 1'b1);
    @(posedge clock); #1;
    awvalid = 1'b0;
    commit_c = cycle;
    for (int i = 0; i <= int'(len); i++) begin
      chk("wready", wready, 1'b1);
      wdata = data; wstrb = strb; wlast = (i == int'(len)); wvalid = 1'b1;
      commit_c = cycle;
      @(posedge clock); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid", bvalid, 1'b1);
    chk("bresp", bresp, eresp);
    chk("bid", bid, id);
    bready = 1'b1;
    @(posedge clock); #1;
    bready = 1'b0;
    chk("b_done", bvalid, 1'b0);
  endtask

  initial begin
    int          hs, c;
    logic [31:0] r1, r2;
    logic [63:0] e64;
    n_cmp = 0; n_err = 0;
    reset = 1'b1;
    araddr = '0; arvalid = 1'b0; arid = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01;
    awaddr = '0; awvalid = 1'b0; awid = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01;
    wdata = '0; wstrb = '0; wvalid = 1'b0; wlast = 1'b0; rready = 1'b0; bready = 1'b0;

    // Reset values
    do_reset();
    chk("rst_arready", arready, 1'b1);
    chk("rst_awready", awready, 1'b1);
    chk("rst_wready", wready, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rlast", rlast, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_resp", {rresp, bresp}, 4'h0);
    chk("rst_ids", {rid, bid}, 8'h00);
    chk("rst_irq", {mtip, msip}, 4'h0);
    chk("rst_state", dbg_state, 3'b000);
    chk("rst_d4_ready", {arready_d4, awready_d4}, 2'b11);

    // mtime after 10 idle cycles; TICK_DIV=4 instance advances once per 4 cycles
    wait_until(10);
    exp_q.push_back(32'(cycle));
    axi_read(32'h0200_BFF8, 8'd0, 4'h5, 0, 2'b00, hs);
    chk("mtime_hs_cycle", hs, 10);
    r1 = rdata_d4;
    chk("d4_mtime_a", r1, 32'(hs / 4));
    wait_until(hs + 39);
    exp_q.push_back(32'(cycle));
    axi_read(32'h0200_BFF8, 8'd0, 4'h9, 0, 2'b00, c);
    r2 = rdata_d4;
    chk("d4_mtime_b", r2, 32'(c / 4));
    chk("d4_delta", r2 - r1, 32'd10);

    // mtimecmp[0] = 20: mtip rises the cycle after mtime reaches 20
    do_reset();
    axi_write(32'h0200_4000, 8'd0, 32'd20, 4'hF, 4'h1, 2'b00, c);
    axi_write(32'h0200_4004, 8'd0, 32'd0, 4'hF, 4'h2, 2'b00, c);
    wait_until(20);
    chk("mtip_at_20", mtip, 2'b00);
    @(posedge clock); #1;
    chk("mtip_at_21", mtip, 2'b01);
    exp_q.push_back(32'd20);
    axi_read(32'h0200_4000, 8'd0, 4'h3, 0, 2'b00, hs);
    axi_write(32'h0200_4004, 8'd0, 32'd1, 4'hF, 4'h4, 2'b00, c);
    chk("mtip_cleared", mtip, 2'b00);

    // msip byte strobes and read-back
    axi_write(32'h0200_0000, 8'd0, 32'h1, 4'h1, 4'h3, 2'b00, c);
    chk("msip_set", msip, 2'b01);
    exp_q.push_back(32'h1);
    axi_read(32'h0200_0000, 8'd0, 4'h2, 0, 2'b00, hs);
    axi_write(32'h0200_0000, 8'd0, 32'h0, 4'h0, 4'h3, 2'b00, c);
    chk("msip_nostrb", msip, 2'b01);
    axi_write(32'h0200_0004, 8'd0, 32'hFFFF_FFFF, 4'hF, 4'hA, 2'b00, c);
    chk("msip1_set", msip, 2'b11);
    exp_q.push_back(32'h1);
    axi_read(32'h0200_0004, 8'd0, 4'hB, 0, 2'b00, hs);

    // Bursts and unmapped accesses report SLVERR; burst writes change nothing
    exp_q.push_back(32'd20);
    axi_read(32'h0200_4000, 8'd3, 4'h6, 5, 2'b10, hs);
    axi_write(32'h0200_0000, 8'd1, 32'h0, 4'hF, 4'h7, 2'b10, c);
    chk("burst_no_write", msip, 2'b11);
    exp_q.push_back(32'h0);
    axi_read(32'h0200_1000, 8'd0, 4'h8, 0, 2'b10, hs);
    exp_q.push_back(32'h0);
    axi_read(32'h0300_BFF8, 8'd0, 4'hC, 0, 2'b10, hs);
    axi_write(32'h0200_1000, 8'd0, 32'h1, 4'hF, 4'hD, 2'b10, c);

    // mtime write with carry into the upper half
    axi_write(32'h0200_BFFC, 8'd0, 32'h0, 4'hF, 4'hE, 2'b00, c);
    axi_write(32'h0200_BFF8, 8'd0, 32'hFFFF_FFFF, 4'hF, 4'hF, 2'b00, c);
    e64 = 64'hFFFF_FFFF + 64'(cycle - c - 1);
    exp_q.push_back(e64[63:32]);
    axi_read(32'h0200_BFFC, 8'd0, 4'h1, 0, 2'b00, hs);
    chk("carry_hi", e64[63:32], 32'h1);
    e64 = 64'hFFFF_FFFF + 64'(cycle - c - 1);
    exp_q.push_back(e64[31:0]);
    axi_read(32'h0200_BFF8, 8'd0, 4'h2, 0, 2'b00, hs);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
